// File: rtl/suspend_ctrl_if.sv
// Suspend controller port bundle between core pipeline control and the LALU top level.
//   master: core side; drives halt_req/halt_timer/pipe_empty/mem_busy/wake and
//           observes core_en/suspended/resumed/drain_err/susp_cycles.
//   slave : suspend_ctrl side (directions reversed).
interface suspend_ctrl_if #(
  parameter int unsigned TW = 16,
  parameter int unsigned CW = 24
);
  logic          halt_req;
  logic [TW-1:0] halt_timer;
  logic          pipe_empty;
  logic          mem_busy;
  logic          wake;
  logic          core_en;
  logic          suspended;
  logic          resumed;
  logic          drain_err;
  logic [CW-1:0] susp_cycles;

  modport master (
    output halt_req, halt_timer, pipe_empty, mem_busy, wake,
    input  core_en, suspended, resumed, drain_err, susp_cycles
  );

  modport slave (
    input  halt_req, halt_timer, pipe_empty, mem_busy, wake,
    output core_en, suspended, resumed, drain_err, susp_cycles
  );
endinterface

// File: rtl/suspend_ctrl.sv
// Suspend controller: drains in-flight traffic on a core suspend request,
// freezes the pipeline, holds `suspended` until wake or sleep-timer expiry,
// then restarts the core through a one-cycle WAKE state.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - suspend_ctrl_if.slave: halt_req, halt_timer, pipe_empty, mem_busy,
//          wake in; core_en, suspended, resumed, drain_err, susp_cycles out
//          (all outputs registered)
module suspend_ctrl #(
  parameter int unsigned TW        = 16,
  parameter int unsigned CW        = 24,
  parameter int unsigned DRAIN_MAX = 64
) (
  input logic           clk,
  input logic           rst,
  suspend_ctrl_if.slave bus
);

  localparam int unsigned DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SUSP  = 2'd2,
    WAKE  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer_lat;
  logic [TW-1:0] sleep_cnt;
  logic [DW-1:0] drain_cnt;
  logic          wake_pend;
  logic          core_en_q;
  logic          suspended_q;
  logic          resumed_q;
  logic          drain_err_q;
  logic [CW-1:0] susp_cycles_q;

  assign bus.core_en     = core_en_q;
  assign bus.suspended   = suspended_q;
  assign bus.resumed     = resumed_q;
  assign bus.drain_err   = drain_err_q;
  assign bus.susp_cycles = susp_cycles_q;

  // Drain is complete once nothing is in flight past fetch and memory is idle.
  logic drain_done_c;
  assign drain_done_c = bus.pipe_empty & ~bus.mem_busy;

  // Drain cycle count is 0-based, so DRAIN_MAX-1 marks the last permitted drain cycle.
  logic drain_limit_c;
  assign drain_limit_c = (drain_cnt == DW'(DRAIN_MAX - 1));

  // A nonzero sleep count expires on its final SUSP cycle; zero never expires.
  logic timer_exp_c;
  assign timer_exp_c = (sleep_cnt == TW'(1));

  // Controller state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      timer_lat     <= '0;
      sleep_cnt     <= '0;
      drain_cnt     <= '0;
      wake_pend     <= 1'b0;
      core_en_q     <= 1'b1;
      suspended_q   <= 1'b0;
      resumed_q     <= 1'b0;
      drain_err_q   <= 1'b0;
      susp_cycles_q <= '0;
    end else begin
      resumed_q <= 1'b0;
      unique case (state)
        RUN: begin
          // wake is deliberately not looked at here, even on the halt edge.
          if (bus.halt_req) begin
            state     <= DRAIN;
            core_en_q <= 1'b0;
            timer_lat <= bus.halt_timer;
            drain_cnt <= '0;
          end
        end

        DRAIN: begin
          if (bus.wake) begin
            wake_pend <= 1'b1;
          end
          if (drain_done_c || drain_limit_c) begin
            state         <= SUSP;
            suspended_q   <= 1'b1;
            susp_cycles_q <= '0;
            sleep_cnt     <= timer_lat;
            // A clean drain on the limit cycle still counts as clean.
            if (!drain_done_c) begin
              drain_err_q <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        SUSP: begin
          if (susp_cycles_q != '1) begin
            susp_cycles_q <= susp_cycles_q + CW'(1);
          end
          // All wake sources merge into one exit, so only one resumed pulse results.
          if (bus.wake || wake_pend || timer_exp_c) begin
            state       <= WAKE;
            suspended_q <= 1'b0;
            resumed_q   <= 1'b1;
          end else if (sleep_cnt != '0) begin
            sleep_cnt <= sleep_cnt - TW'(1);
          end
        end

        WAKE: begin
          wake_pend <= 1'b0;
          state     <= RUN;
          core_en_q <= 1'b1;
        end

        default: begin
          state       <= RUN;
          core_en_q   <= 1'b1;
          suspended_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_suspend_ctrl.sv
// Self-checking bench for suspend_ctrl: vector table, directed corner sequences,
// and randomized traces checked against a per-suspend timeline model.
module tb_suspend_ctrl;

  localparam int unsigned TW        = 16;
  localparam int unsigned CW        = 24;
  localparam int unsigned DRAIN_MAX = 64;
  localparam int          NMAX      = 512;
  localparam int          NRUN      = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  suspend_ctrl_if #(.TW(TW), .CW(CW)) bus ();

  suspend_ctrl #(.TW(TW), .CW(CW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    bit h; int t; bit p; bit m; bit w;
    bit ce; bit su; bit re; longint sc;
  } vec_t;
  vec_t vecs[$];

  // Random trace inputs and timeline-model expectations.
  bit     r_h[NMAX];
  int     r_t[NMAX];
  bit     r_p[NMAX];
  bit     r_m[NMAX];
  bit     r_w[NMAX];
  bit     e_ce[NMAX];
  bit     e_su[NMAX];
  bit     e_re[NMAX];
  bit     e_de[NMAX];
  longint e_sc[NMAX];

  function automatic longint pack(bit ce, bit su, bit re, bit de, longint sc);
    return (longint'({ce, su, re, de}) << CW) | sc;
  endfunction

  function automatic longint sat(longint v);
    longint mx;
    mx = (longint'(1) << CW) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Compares all outputs at once: {core_en,suspended,resumed,drain_err,susp_cycles}.
  task automatic chk_out(input string name, input bit ce, input bit su, input bit re,
                         input bit de, input longint sc);
    chk(name, pack(bus.core_en, bus.suspended, bus.resumed, bus.drain_err,
                   longint'(bus.susp_cycles)), pack(ce, su, re, de, sc));
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit before sampling.
  task automatic step(input bit h, input int t, input bit p, input bit m, input bit w);
    bus.halt_req   = h;
    bus.halt_timer = TW'(t);
    bus.pipe_empty = p;
    bus.mem_busy   = m;
    bus.wake       = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.halt_req = 1'b0; bus.halt_timer = '0; bus.pipe_empty = 1'b1;
    bus.mem_busy = 1'b0; bus.wake = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add(input bit h, input int t, input bit p, input bit m, input bit w,
                     input bit ce, input bit su, input bit re, input longint sc);
    vec_t v;
    v.h = h; v.t = t; v.p = p; v.m = m; v.w = w;
    v.ce = ce; v.su = su; v.re = re; v.sc = sc;
    vecs.push_back(v);
  endtask

  function automatic void set_exp(int n, int c, bit ce, bit su, bit re, bit de, longint sc);
    if (c >= 0 && c < n) begin
      e_ce[c] = ce; e_su[c] = su; e_re[c] = re; e_de[c] = de; e_sc[c] = sc;
    end
  endfunction

  // Timeline model: each suspend episode is laid out from its halt edge using
  // the drain exit edge d and the wake edge x; index c = outputs after edge c.
  task automatic build_model(input int n);
    int c, h, d, x, t;
    bit err, wp, de;
    longint last_sc;
    c = 0; de = 1'b0; last_sc = 0;
    while (c < n) begin
      if (!r_h[c]) begin
        set_exp(n, c, 1'b1, 1'b0, 1'b0, de, last_sc);
        c++;
      end else begin
        h = c; t = r_t[h];
        d = h + DRAIN_MAX; err = 1'b1;
        for (int e = h + 1; e <= h + DRAIN_MAX; e++) begin
          if (err && r_p[e] && !r_m[e]) begin d = e; err = 1'b0; end
        end
        for (int e = h; e < d; e++) set_exp(n, e, 1'b0, 1'b0, 1'b0, de, last_sc);
        wp = 1'b0;
        for (int e = h + 1; e <= d; e++) if (r_w[e]) wp = 1'b1;
        if (err) de = 1'b1;
        x = -1;
        for (int e = d + 1; e <= n && x < 0; e++) begin
          if (r_w[e] || wp || (t > 0 && e - d == t)) x = e;
        end
        if (x < 0) x = n + 1;
        for (int e = d; e < x; e++) set_exp(n, e, 1'b0, 1'b1, 1'b0, de, sat(longint'(e - d)));
        last_sc = sat(longint'(x - d));
        set_exp(n, x, 1'b0, 1'b0, 1'b1, de, last_sc);
        set_exp(n, x + 1, 1'b1, 1'b0, 1'b0, de, last_sc);
        c = x + 2;
      end
    end
  endtask

  task automatic rand_run(input int run, input int hp, input int pp, input int mp, input int wp);
    for (int i = 0; i < NMAX; i++) begin
      r_h[i] = ($urandom_range(0, 99) < hp);
      r_t[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
      r_p[i] = ($urandom_range(0, 99) < pp);
      r_m[i] = ($urandom_range(0, 99) < mp);
      r_w[i] = ($urandom_range(0, 99) < wp);
    end
    build_model(NRUN);
    do_reset();
    for (int c = 0; c < NRUN; c++) begin
      step(r_h[c], r_t[c], r_p[c], r_m[c], r_w[c]);
      chk_out($sformatf("rand%0d_c%0d", run, c), e_ce[c], e_su[c], e_re[c], e_de[c], e_sc[c]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit prev_de;

    // Vectors: timed suspend, wake during drain, halt+wake on the same RUN edge.
    add(1, 5, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 1);
    add(0, 0, 1, 0, 0,  0, 1, 0, 2);
    add(0, 0, 1, 0, 0,  0, 1, 0, 3);
    add(0, 0, 1, 0, 0,  0, 1, 0, 4);
    add(0, 0, 1, 0, 0,  0, 0, 1, 5);
    add(0, 0, 1, 0, 0,  1, 0, 0, 5);
    add(1, 0, 0, 0, 0,  0, 0, 0, 5);
    add(0, 0, 0, 0, 1,  0, 0, 0, 5);
    add(0, 0, 1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 1, 1);
    add(0, 0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 0, 1, 0, 1,  1, 0, 0, 1);
    add(1, 3, 1, 0, 1,  0, 0, 0, 1);
    add(0, 0, 1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 1);
    add(0, 0, 1, 0, 0,  0, 1, 0, 2);
    add(0, 0, 1, 0, 0,  0, 0, 1, 3);
    add(0, 0, 1, 0, 0,  1, 0, 0, 3);

    do_reset();
    chk_out("reset_state", 1, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].h, vecs[i].t, vecs[i].p, vecs[i].m, vecs[i].w);
      chk_out($sformatf("vec%0d", i), vecs[i].ce, vecs[i].su, vecs[i].re, 1'b0, vecs[i].sc);
    end

    // Indefinite sleep behind a 10-cycle memory stall, woken after 20 SUSP cycles.
    do_reset();
    step(1, 0, 1, 1, 0);
    repeat (10) step(0, 0, 1, 1, 0);
    chk_out("memstall_drain", 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_out("memstall_susp_entry", 0, 1, 0, 0, 0);
    repeat (19) step(0, 0, 1, 0, 0);
    chk_out("memstall_still_susp", 0, 1, 0, 0, 19);
    step(0, 0, 1, 0, 1);
    chk_out("memstall_wake", 0, 0, 1, 0, 20);
    step(0, 0, 1, 0, 0);
    chk_out("memstall_run", 1, 0, 0, 0, 20);

    // Drain timeout: pipe never empties; forced suspend after DRAIN_MAX cycles.
    do_reset();
    step(1, 2, 0, 0, 0);
    n = 0; prev_de = 1'b0;
    while (!bus.suspended && n < 100) begin
      prev_de = bus.drain_err;
      step(0, 2, 0, 0, 0);
      n++;
    end
    chk("timeout_drain_cycles", longint'(n), longint'(DRAIN_MAX));
    chk("timeout_err_before", longint'(prev_de), 0);
    chk_out("timeout_forced_susp", 0, 1, 0, 1, 0);
    n = 0;
    while (!bus.core_en && n < 10) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk("timeout_resume_cycles", longint'(n), 3);
    chk_out("timeout_err_sticky", 1, 0, 0, 1, 2);

    // halt_req during SUSP ignored; wake coinciding with timer expiry gives one pulse.
    do_reset();
    step(1, 4, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_out("dup_susp0", 0, 1, 0, 0, 0);
    step(1, 9, 1, 0, 0);
    chk_out("dup_halt_in_susp1", 0, 1, 0, 0, 1);
    step(1, 9, 1, 0, 0);
    chk_out("dup_halt_in_susp2", 0, 1, 0, 0, 2);
    step(0, 0, 1, 0, 0);
    chk_out("dup_susp3", 0, 1, 0, 0, 3);
    step(0, 0, 1, 0, 1);
    chk_out("dup_wake_and_expiry", 0, 0, 1, 0, 4);
    step(0, 0, 1, 0, 1);
    chk_out("dup_back_to_run", 1, 0, 0, 0, 4);
    step(0, 0, 1, 0, 1);
    chk_out("dup_no_second_pulse", 1, 0, 0, 0, 4);
    step(0, 0, 1, 0, 1);
    chk_out("dup_wake_in_run", 1, 0, 0, 0, 4);

    // Asynchronous reset during a long, error-flagged suspend.
    do_reset();
    step(1, 1000, 0, 0, 0);
    repeat (DRAIN_MAX) step(0, 0, 0, 0, 0);
    chk_out("rst_pre_susp", 0, 1, 0, 1, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    chk_out("rst_pre_count", 0, 1, 0, 1, 5);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 1, 0, 0);
    chk_out("rst_after_release", 1, 0, 0, 0, 0);

    // Randomized traces: normal mix, frequent timeouts, heavy wake traffic.
    rand_run(0, 8, 75, 25, 3);
    rand_run(1, 6, 2, 10, 1);
    rand_run(2, 20, 60, 40, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
